// File: rtl/port_pkg.sv
// Shared definitions for the GPIO port input stage.
//  - Register offsets of the input/interrupt register window.
//  - Per-pin debounce state type.
package port_pkg;

    localparam logic [1:0] PIRQ_ADR_IN     = 2'd0;
    localparam logic [1:0] PIRQ_ADR_IFLAG  = 2'd1;
    localparam logic [1:0] PIRQ_ADR_IMASK  = 2'd2;
    localparam logic [1:0] PIRQ_ADR_ISENSE = 2'd3;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } pin_deb_state_e;

endpackage

// File: rtl/pin_debounce.sv
// One GPIO input pin: synchroniser chain, debounce counter and edge detect.
// Ports:
//  clk, rst  clock, asynchronous active-high reset
//  pad       raw pad value (asynchronous to clk)
//  en        input enable; 0 feeds 0 into the synchroniser
//  deb_cnt   debounce length in cycles (0 = none)
//  stable    debounced value
//  rise/fall stable is about to go 0->1 / 1->0 on the next clock edge
module pin_debounce
    import port_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad,
    input  logic             en,
    input  logic [DEB_W-1:0] deb_cnt,
    output logic             stable,
    output logic             rise,
    output logic             fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   stable_q, stable_d;
    logic [DEB_W-1:0]       cnt_q, cnt_d;
    pin_deb_state_e         state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pad & en};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state    = (s != stable_q) ? CHANGING : STABLE;
        stable_d = stable_q;
        cnt_d    = '0;
        unique case (state)
            STABLE: cnt_d = '0;
            CHANGING: begin
                // >= so that lowering deb_cnt mid-count expires on the next compare
                // instead of waiting for the counter to wrap.
                if (cnt_q >= deb_cnt) begin
                    stable_d = s;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign stable = stable_q;
    assign rise   = ~stable_q & stable_d;
    assign fall   = stable_q & ~stable_d;

endmodule

// File: rtl/port_input_irq.sv
// Input side of one GPIO port: per-pin synchronise/debounce, pin-change
// interrupt flags and the IN/IFLAG/IMASK/ISENSE register window.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  pad_in     raw pad inputs          input_en  per-pin input enable
//  deb_cnt    debounce length         adr/we/re/mdata  register bus request
//  sdata      read data (comb.)       ws        wait state, always 0
//  in_stable  debounced pin values    irq       OR of (IFLAG & IMASK)
module port_input_irq
    import port_pkg::*;
#(
    parameter int unsigned NPINS       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPINS-1:0] pad_in,
    input  logic [NPINS-1:0] input_en,
    input  logic [DEB_W-1:0] deb_cnt,
    input  logic [1:0]       adr,
    input  logic [1:0]       we,
    input  logic [1:0]       re,
    input  logic [15:0]      mdata,
    output logic [15:0]      sdata,
    output logic             ws,
    output logic [NPINS-1:0] in_stable,
    output logic             irq
);

    logic [NPINS-1:0] rise, fall;
    logic [NPINS-1:0] iflag_q, iflag_d;
    logic [NPINS-1:0] imask_q, imask_d;
    logic [NPINS-1:0] isr_q, isr_d;
    logic [NPINS-1:0] isf_q, isf_d;
    logic [NPINS-1:0] flag_set, flag_clr;
    logic [7:0]       in8, iflag8, imask8, isr8, isf8;
    logic             unused_re;

    for (genvar gi = 0; gi < NPINS; gi++) begin : gen_pin
        pin_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
        ) u_pin (
            .clk     (clk),
            .rst     (rst),
            .pad     (pad_in[gi]),
            .en      (input_en[gi]),
            .deb_cnt (deb_cnt),
            .stable  (in_stable[gi]),
            .rise    (rise[gi]),
            .fall    (fall[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iflag_q <= '0;
            imask_q <= '0;
            isr_q   <= '0;
            isf_q   <= '0;
        end else begin
            iflag_q <= iflag_d;
            imask_q <= imask_d;
            isr_q   <= isr_d;
            isf_q   <= isf_d;
        end
    end

    always_comb begin
        flag_set = (rise & isr_q) | (fall & isf_q);
        flag_clr = '0;
        imask_d  = imask_q;
        isr_d    = isr_q;
        isf_d    = isf_q;
        if (adr == PIRQ_ADR_IFLAG && we[0]) begin
            flag_clr = mdata[NPINS-1:0];
        end
        if (adr == PIRQ_ADR_IMASK && we[0]) begin
            imask_d = mdata[NPINS-1:0];
        end
        if (adr == PIRQ_ADR_ISENSE) begin
            if (we[0]) isr_d = mdata[NPINS-1:0];
            if (we[1]) isf_d = mdata[NPINS+7:8];
        end
        // A new edge outranks a W1C of the same bit.
        iflag_d = (iflag_q & ~flag_clr) | flag_set;
    end

    // Zero-extend to byte width so bits >= NPINS read as 0.
    always_comb begin
        in8    = '0;
        iflag8 = '0;
        imask8 = '0;
        isr8   = '0;
        isf8   = '0;
        in8[NPINS-1:0]    = in_stable;
        iflag8[NPINS-1:0] = iflag_q;
        imask8[NPINS-1:0] = imask_q;
        isr8[NPINS-1:0]   = isr_q;
        isf8[NPINS-1:0]   = isf_q;
    end

    always_comb begin
        sdata = 16'h0000;
        unique case (adr)
            PIRQ_ADR_IN:     sdata = {8'h00, in8};
            PIRQ_ADR_IFLAG:  sdata = {8'h00, iflag8};
            PIRQ_ADR_IMASK:  sdata = {8'h00, imask8};
            PIRQ_ADR_ISENSE: sdata = {isf8, isr8};
            default:         sdata = 16'h0000;
        endcase
    end

    // Reads have no side effects, so the read strobes are not needed.
    assign unused_re = ^re;
    assign ws        = 1'b0;
    assign irq       = |(iflag_q & imask_q);

endmodule

// File: tb/tb_port_input_irq.sv
module tb_port_input_irq;

    localparam int NPINS = 8;
    localparam int SYNC  = 2;
    localparam int DEB_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pad_in, input_en;
    logic [3:0]  deb_cnt;
    logic [1:0]  adr, we, re;
    logic [15:0] mdata, sdata;
    logic        ws, irq;
    logic [7:0]  in_stable;

    always #5 clk = ~clk;

    port_input_irq #(
        .NPINS       (NPINS),
        .SYNC_STAGES (SYNC),
        .DEB_W       (DEB_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_in    (pad_in),
        .input_en  (input_en),
        .deb_cnt   (deb_cnt),
        .adr       (adr),
        .we        (we),
        .re        (re),
        .mdata     (mdata),
        .sdata     (sdata),
        .ws        (ws),
        .in_stable (in_stable),
        .irq       (irq)
    );

    typedef struct {
        logic [7:0]  ins;
        logic        irq;
        bit          rd;
        logic [1:0]  adr;
        logic [15:0] sd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a pin's stable value follows its synchronised sample once that
    // sample has held a value different from stable for deb_cnt+1 consecutive compares.
    logic [7:0] m_stable, m_iflag, m_imask, m_isr, m_isf;
    logic [7:0] hist[$];   // gated pad value captured at each edge
    int         chg[8];    // edge index at which the delayed sample last changed
    int         k;

    function automatic void model_reset();
        m_stable = '0; m_iflag = '0; m_imask = '0; m_isr = '0; m_isf = '0;
        hist.delete();
        for (int i = 0; i < SYNC + 1; i++) hist.push_back(8'h00);
        for (int i = 0; i < 8; i++) chg[i] = -1000;
        k = 0;
    endfunction

    function automatic void model_edge();
        logic [7:0] d, prev, nxt, rise, fall, set, clr;
        k++;
        hist.push_back(pad_in & input_en);
        d    = hist[hist.size() - 1 - SYNC];
        prev = hist[hist.size() - 2 - SYNC];
        nxt  = m_stable;
        for (int i = 0; i < 8; i++) begin
            if (d[i] != prev[i]) chg[i] = k - SYNC;
            if (d[i] != m_stable[i] && (k - SYNC - chg[i]) >= int'(deb_cnt)) nxt[i] = d[i];
        end
        while (hist.size() > SYNC + 2) void'(hist.pop_front());
        rise = ~m_stable & nxt;
        fall = m_stable & ~nxt;
        set  = (rise & m_isr) | (fall & m_isf);
        clr  = (we[0] && adr == 2'd1) ? mdata[7:0] : 8'h00;
        m_iflag = (m_iflag & ~clr) | set;
        if (we[0] && adr == 2'd2) m_imask = mdata[7:0];
        if (adr == 2'd3) begin
            if (we[0]) m_isr = mdata[7:0];
            if (we[1]) m_isf = mdata[15:8];
        end
        m_stable = nxt;
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_stable};
            2'd1:    return {8'h00, m_iflag};
            2'd2:    return {8'h00, m_imask};
            default: return {m_isf, m_isr};
        endcase
    endfunction

    // Issue one clock with the current inputs; expectation goes to the scoreboard.
    task automatic cycle();
        exp_t e;
        if (rst) model_reset();
        else     model_edge();
        e.ins = m_stable;
        e.irq = |(m_iflag & m_imask);
        e.rd  = (re != 2'b00);
        e.adr = adr;
        e.sd  = m_read(adr);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
        we = 2'b00;
        re = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] lanes);
        adr = a; mdata = d; we = lanes;
        cycle();
    endtask

    task automatic rd(input logic [1:0] a);
        adr = a; re = 2'b01;
        cycle();
    endtask

    // Monitor: outputs are presented every cycle; compare against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (in_stable !== e.ins) begin
                errors++;
                $display("FAIL in_stable t=%0t got %h exp %h", $time, in_stable, e.ins);
            end
            checks++;
            if (irq !== e.irq || ws !== 1'b0) begin
                errors++;
                $display("FAIL irq/ws t=%0t got irq=%b ws=%b exp irq=%b ws=0", $time, irq, ws,
                         e.irq);
            end
            if (e.rd) begin
                checks++;
                if (sdata !== e.sd) begin
                    errors++;
                    $display("FAIL sdata adr=%0d t=%0t got %h exp %h", e.adr, $time, sdata,
                             e.sd);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pad_in = '0; input_en = 8'hFF; deb_cnt = '0;
        adr = '0; we = '0; re = '0; mdata = '0;
        model_reset();
        idle(2);
        rd(2'd0);
        rst = 1'b0;
        idle(2);
        rd(2'd3);

        // 1: no debounce, rising edge on pin 0, then W1C
        deb_cnt = 4'd0;
        wr(2'd3, 16'h0001, 2'b11);
        wr(2'd2, 16'h0001, 2'b01);
        pad_in[0] = 1'b1;
        idle(3);
        rd(2'd1);
        wr(2'd1, 16'h0001, 2'b01);
        idle(2);
        rd(2'd1);

        // 2: debounce 3, short glitch rejected, long pulse accepted
        deb_cnt = 4'd3;
        wr(2'd3, 16'h0004, 2'b11);
        pad_in[2] = 1'b1; idle(3);
        pad_in[2] = 1'b0; idle(8);
        rd(2'd1);
        pad_in[2] = 1'b1; idle(10);
        rd(2'd0);

        // 3: falling edge on pin 7 coincides with W1C of a pending flag
        deb_cnt = 4'd0;
        wr(2'd3, 16'h8000, 2'b11);
        pad_in[7] = 1'b1; idle(5);
        pad_in[7] = 1'b0; idle(5);
        rd(2'd1);
        pad_in[7] = 1'b1; idle(5);
        pad_in[7] = 1'b0; cycle(); cycle();
        wr(2'd1, 16'h0080, 2'b01);
        rd(2'd1);

        // 4: masked flag, unmask re-asserts irq
        wr(2'd1, 16'h00FF, 2'b01);
        wr(2'd2, 16'h0000, 2'b01);
        wr(2'd3, 16'h0010, 2'b11);
        pad_in[4] = 1'b1; idle(5);
        rd(2'd1);
        wr(2'd2, 16'h0010, 2'b01);
        rd(2'd2);
        idle(2);

        // 5: inputs disabled
        input_en = 8'h00; pad_in = 8'hFF; idle(10);
        rd(2'd0);
        input_en = 8'hFF; pad_in = 8'h00; idle(6);

        // 6: reset mid-debounce with flags pending
        wr(2'd3, 16'h000F, 2'b11);
        pad_in[3:0] = 4'hF; idle(5);
        rd(2'd1);
        deb_cnt = 4'd5;
        pad_in[5] = 1'b1; idle(3);
        adr = 2'd0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_stable !== 8'h00 || irq !== 1'b0 || sdata !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got in=%h irq=%b sdata=%h exp 00/0/0000", in_stable, irq,
                     sdata);
        end
        idle(2);
        rst = 1'b0;
        idle(12);
        rd(2'd1);
        rd(2'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int op;
            pad_in = pad_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 49) == 0) deb_cnt = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) input_en = 8'($urandom) | 8'hF0;
            op = $urandom_range(0, 5);
            adr = 2'($urandom);
            if (op == 0) begin
                mdata = 16'($urandom);
                we    = 2'($urandom);
            end else if (op == 1) begin
                re = 2'b01;
            end
            cycle();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
